// File: rtl/timer_pkg.sv
// Shared definitions for the timer block: FSM state encoding and default sizing.
package timer_pkg;

  localparam int CNT_W_DEF   = 64;
  localparam int DIV_MAX_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: clamps the exponent, restarts on settings change and
// produces a combinational tick request for the count register in the parent.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int DIV_MAX = DIV_MAX_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       i_run,
  input  logic       i_div_en,
  input  logic [3:0] i_div_val,
  output logic       o_tick
);

  // Counter only ever needs to reach 2^DIV_MAX-1.
  localparam int         PW        = DIV_MAX;
  localparam logic [3:0] DIV_MAX_4 = 4'(DIV_MAX);

  logic [PW-1:0] r_pre;
  logic          r_prev_en;
  logic [3:0]    r_prev_val;

  logic [3:0]    w_eff_div;
  logic [PW-1:0] w_mask;
  logic          w_changed;
  logic [PW-1:0] w_pre_cur;
  logic [PW-1:0] w_pre_nxt;

  // Clamp exponent, build terminal count, decide tick and next prescaler value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_eff_div = (i_div_val > DIV_MAX_4) ? DIV_MAX_4 : i_div_val;
    w_mask    = '0;
    for (int i = 0; i < PW; i++) begin
      w_mask[i] = (4'(i) < w_eff_div);
    end
    // A settings change restarts the period: this cycle counts as phase 0.
    w_changed = (i_div_en != r_prev_en) || (i_div_val != r_prev_val);
    w_pre_cur = w_changed ? '0 : r_pre;
    o_tick    = i_run && (!i_div_en || (w_pre_cur == w_mask));
    w_pre_nxt = '0;
    if (i_run && i_div_en && !o_tick) begin
      w_pre_nxt = w_pre_cur + PW'(1);
    end
  end

  // Prescaler counter and previous-settings registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pre      <= '0;
      r_prev_en  <= 1'b0;
      r_prev_val <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      r_pre      <= w_pre_nxt;
      r_prev_en  <= i_div_en;
      r_prev_val <= i_div_val;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Free-running timer: IDLE/RUN/HALT control, prescaled tick and a 64-bit count
// register that software can load one 32-bit half at a time.
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_MAX = DIV_MAX_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [3:0]       div_val,
  input  logic             dbg_mode,
  input  logic             halt_req,
  input  logic             cnt_wr_lo,
  input  logic             cnt_wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] cnt_val,
  output logic             cnt_tick,
  output logic             halt_ack
);

  localparam int HI_W = CNT_W - 32;

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_cnt_val;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_cnt_tick;
  logic             r_halt_ack;
  logic             w_halt_cond;
  logic             w_count_en;
  logic             w_presc_tick;
  logic             w_wr_any;

  // Next-state logic; a qualified halt request wins over timer_en.
  always_comb begin
    w_halt_cond  = dbg_mode && halt_req;
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_halt_cond)  w_next_state = HALT;
        else if (timer_en) w_next_state = RUN;
      end
      RUN: begin
        if (w_halt_cond)   w_next_state = HALT;
        else if (!timer_en) w_next_state = IDLE;
      end
      HALT: begin
        if (!w_halt_cond) w_next_state = timer_en ? RUN : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Counting happens only while RUN persists, so a halt or disable freezes the
  // count in the request cycle and the prescaler restarts from 0 on return.
  assign w_count_en = (r_state == RUN) && (w_next_state == RUN);

  timer_prescaler #(
    .DIV_MAX (DIV_MAX)
  ) u_prescaler (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_run     (w_count_en),
    .i_div_en  (div_en),
    .i_div_val (div_val),
    .o_tick    (w_presc_tick)
  );

  // Next count: software writes replace the addressed half and suppress the increment.
  always_comb begin
    w_wr_any  = cnt_wr_lo || cnt_wr_hi;
    w_cnt_nxt = r_cnt_val;
    if (cnt_wr_lo) w_cnt_nxt[31:0]       = wdata;
    if (cnt_wr_hi) w_cnt_nxt[CNT_W-1:32] = wdata[HI_W-1:0];
    if (!w_wr_any && w_presc_tick) begin
      w_cnt_nxt = r_cnt_val + CNT_W'(1);
    end
  end

  // State, count, tick and halt acknowledge registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_cnt_val  <= '0;
      r_cnt_tick <= 1'b0;
      r_halt_ack <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt_val  <= w_cnt_nxt;
      r_cnt_tick <= w_presc_tick && !w_wr_any;
      r_halt_ack <= (w_next_state == HALT);
    end
  end

  assign cnt_val  = r_cnt_val;
  assign cnt_tick = r_cnt_tick;
  assign halt_ack = r_halt_ack;

endmodule
